// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared Booth radix-4 digit and multiplier state types
package booth_pkg;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } mult_state_t;

  function automatic booth_digit_t booth_encode(input logic [2:0] window);
    booth_digit_t digit;
    case (window)
      3'b001, 3'b010: digit = BD_POS1;
      3'b011:         digit = BD_POS2;
      3'b100:         digit = BD_NEG2;
      3'b101, 3'b110: digit = BD_NEG1;
      default:        digit = BD_ZERO;
    endcase
    return digit;
  endfunction

endpackage

// File: rtl/booth_r4_digit_sel.sv
// rtl/booth_r4_digit_sel.sv - selects the magnitude multiple and negate flag for one Booth window
module booth_r4_digit_sel
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       window,
  input  logic [WIDTH+1:0] mcand,
  output logic [WIDTH+2:0] multiple,
  output logic             negate
);

  booth_digit_t digit;

  // Negation is left to the consumer as ~multiple plus a carry-in.
  always_comb begin
    digit    = booth_encode(window);
    multiple = '0;
    negate   = 1'b0;
    case (digit)
      BD_POS1: multiple = {mcand[WIDTH+1], mcand};
      BD_POS2: multiple = {mcand, 1'b0};
      BD_NEG1: begin
        multiple = {mcand[WIDTH+1], mcand};
        negate   = 1'b1;
      end
      BD_NEG2: begin
        multiple = {mcand, 1'b0};
        negate   = 1'b1;
      end
      default: multiple = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per clock
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int CNT_W = $clog2(WIDTH/2 + 2);
  localparam logic [CNT_W-1:0] LAST_S = CNT_W'(WIDTH/2 - 1);
  localparam logic [CNT_W-1:0] LAST_U = CNT_W'(WIDTH/2);

  mult_state_t      state;
  logic [WIDTH+1:0] mcand;
  logic [WIDTH+2:0] acc;
  logic [WIDTH+1:0] breg;
  logic             bm1;
  logic             sgn;
  logic [TAG_W-1:0] tag;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+2:0]   multiple;
  logic               negate;
  logic [WIDTH+2:0]   sum;
  logic [WIDTH+2:0]   acc_nxt;
  logic [WIDTH+1:0]   breg_nxt;
  logic [2*WIDTH-1:0] prod;
  logic               last;

  booth_r4_digit_sel #(.WIDTH(WIDTH)) u_sel (
    .window   ({breg[1:0], bm1}),
    .mcand    (mcand),
    .multiple (multiple),
    .negate   (negate)
  );

  // {acc, breg} is one shift register; product low bits enter breg from the top.
  always_comb begin
    sum      = acc + (negate ? ~multiple : multiple) + {{(WIDTH+2){1'b0}}, negate};
    acc_nxt  = {{2{sum[WIDTH+2]}}, sum[WIDTH+2:2]};
    breg_nxt = {sum[1:0], breg[WIDTH+1:2]};
    // Unsigned runs one extra digit, so the product sits two bits lower.
    prod     = sgn ? {acc_nxt[WIDTH-1:0], breg_nxt[WIDTH+1:2]}
                   : {acc_nxt[WIDTH-3:0], breg_nxt};
    last     = (cnt == (sgn ? LAST_S : LAST_U));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      mcand      <= '0;
      acc        <= '0;
      breg       <= '0;
      bm1        <= 1'b0;
      sgn        <= 1'b0;
      tag        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mcand    <= in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
            breg     <= in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
            acc      <= '0;
            bm1      <= 1'b0;
            sgn      <= in_signed;
            tag      <= in_tag;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc  <= acc_nxt;
          breg <= breg_nxt;
          bm1  <= breg[1];
          cnt  <= cnt + 1'b1;
          if (last) begin
            out_valid  <= 1'b1;
            out_result <= prod;
            out_tag    <= tag;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - self-checking bench for booth_r4_seq_mult at WIDTH 32 and 8
module tb_booth_r4_seq_mult;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        iv32 = 0, rdy32, sg32 = 0, ov32, or32 = 0;
  logic [31:0] a32 = 0, b32 = 0;
  logic [3:0]  tg32 = 0, otag32;
  logic [63:0] res32;

  logic        iv8 = 0, rdy8, sg8 = 0, ov8, or8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [3:0]  tg8 = 0, otag8;
  logic [15:0] res8;

  int n_checks = 0;
  int n_fail = 0;

  booth_r4_seq_mult #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .reset(reset), .in_valid(iv32), .in_ready(rdy32), .in_a(a32), .in_b(b32),
    .in_signed(sg32), .in_tag(tg32), .out_valid(ov32), .out_ready(or32),
    .out_result(res32), .out_tag(otag32)
  );

  booth_r4_seq_mult #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(rdy8), .in_a(a8), .in_b(b8),
    .in_signed(sg8), .in_tag(tg8), .out_valid(ov8), .out_ready(or8),
    .out_result(res8), .out_tag(otag8)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Exact product from integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input int w);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
    return p;
  endfunction

  function automatic int model_lat(input logic s, input int w);
    return s ? w/2 : w/2 + 1;
  endfunction

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [3:0] t, input int stall,
                      output logic [63:0] res, output logic [3:0] tg, output int lat);
    int n;
    n = 0;
    while (!rdy32 && n < 200) begin @(posedge clk); #1; n++; end
    a32 = a; b32 = b; sg32 = s; tg32 = t; iv32 = 1;
    @(posedge clk); #1;
    iv32 = 0; a32 = $urandom; b32 = $urandom; sg32 = ~s; tg32 = 4'($urandom);
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ov32 && lat < 200);
    res = res32; tg = otag32;
    repeat (stall) begin @(posedge clk); #1; end
    or32 = 1;
    @(posedge clk); #1;
    or32 = 0;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n, lat;
    logic [3:0] t;
    t = 4'($urandom);
    n = 0;
    while (!rdy8 && n < 50) begin @(posedge clk); #1; n++; end
    a8 = a; b8 = b; sg8 = s; tg8 = t; iv8 = 1;
    @(posedge clk); #1;
    iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sg8 = ~s;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ov8 && lat < 50);
    chk($sformatf("w8 %h*%h s%0d", a, b, s), {48'd0, res8}, model({24'd0, a}, {24'd0, b}, s, 8));
    chk("w8 latency", 64'(lat), 64'(model_lat(s, 8)));
    chk("w8 tag", {60'd0, otag8}, {60'd0, t});
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    or8 = 1;
    @(posedge clk); #1;
    or8 = 0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [3:0]  tag;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [63:0] r;
    logic [3:0]  tg;
    int          lat;
    logic [7:0]  corner[10];

    vecs.push_back('{32'hFFFFFFF9, 32'd3,        1'b1, 4'h1, 64'hFFFFFFFF_FFFFFFEB, 16});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h2, 64'hFFFFFFFE_00000001, 17});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 4'h3, 64'h00000000_00000001, 16});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 4'h4, 64'h40000000_00000000, 16});
    vecs.push_back('{32'h80000000, 32'h7FFFFFFF, 1'b1, 4'h5, 64'hC0000000_80000000, 16});
    vecs.push_back('{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 4'h6, 64'h3FFFFFFF_00000001, 16});
    vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 4'h7, 64'h7FFFFFFF_80000000, 17});
    vecs.push_back('{32'd0,        32'd0,        1'b0, 4'h8, 64'd0,                 17});
    vecs.push_back('{32'd5,        32'd6,        1'b1, 4'h9, 64'd30,                16});

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {63'd0, rdy32}, 64'd1);
    chk("reset out_valid", {63'd0, ov32}, 64'd0);
    chk("reset out_result", res32, 64'd0);
    chk("reset out_tag", {60'd0, otag32}, 64'd0);
    reset = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      op32(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].tag, 0, r, tg, lat);
      chk($sformatf("vec%0d result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d tag", i), {60'd0, tg}, {60'd0, vecs[i].tag});
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Backpressure: hold the result for 5 cycles while an upstream op is waiting.
    a32 = 32'd1234; b32 = 32'd5678; sg32 = 1; tg32 = 4'hA; iv32 = 1;
    @(posedge clk); #1;
    iv32 = 0;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ov32 && lat < 200);
    chk("bp latency", 64'(lat), 64'd16);
    a32 = 32'd99; b32 = 32'd99; iv32 = 1;
    for (int k = 0; k < 5; k++) begin
      chk("bp result stable", res32, 64'd7006652);
      chk("bp tag stable", {60'd0, otag32}, 64'hA);
      chk("bp in_ready low", {63'd0, rdy32}, 64'd0);
      chk("bp out_valid held", {63'd0, ov32}, 64'd1);
      @(posedge clk); #1;
    end
    iv32 = 0; or32 = 1;
    @(posedge clk); #1;
    or32 = 0;
    chk("bp release out_valid", {63'd0, ov32}, 64'd0);
    chk("bp release in_ready", {63'd0, rdy32}, 64'd1);

    // Reset on the 8th RUN cycle discards the op.
    a32 = 32'hDEADBEEF; b32 = 32'h12345678; sg32 = 0; tg32 = 4'h5; iv32 = 1;
    @(posedge clk); #1;
    iv32 = 0;
    repeat (7) begin @(posedge clk); #1; end
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("midrun reset out_valid", {63'd0, ov32}, 64'd0);
    chk("midrun reset in_ready", {63'd0, rdy32}, 64'd1);
    chk("midrun reset out_result", res32, 64'd0);
    repeat (20) begin @(posedge clk); #1; end
    chk("midrun no late result", {63'd0, ov32}, 64'd0);
    op32(32'd5, 32'd6, 1'b1, 4'h3, 0, r, tg, lat);
    chk("after reset 5*6", r, 64'd30);
    chk("after reset latency", 64'(lat), 64'd16);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b;
      logic s;
      logic [3:0] t;
      a = $urandom; b = $urandom; s = 1'($urandom); t = 4'($urandom);
      op32(a, b, s, t, $urandom_range(0, 3), r, tg, lat);
      chk($sformatf("rand32 %h*%h s%0d", a, b, s), r, model(a, b, s, 32));
      chk("rand32 latency", 64'(lat), 64'(model_lat(s, 32)));
      chk("rand32 tag", {60'd0, tg}, {60'd0, t});
    end

    corner = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF, 8'h55, 8'hAA};
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        for (int s = 0; s < 2; s++)
          op8(corner[i], corner[j], 1'(s));
    for (int i = 0; i < 1500; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
